// File: rtl/rv32v_vcfg_unit.sv
// RV32V vector-configuration unit: executes vsetvli/vsetivli/vsetvl and holds vl/vtype/vlmax.
// Define RV32V_FRAC_LMUL_EN to accept fractional LMUL (vlmul 101/110/111); otherwise those set vill.
module rv32v_vcfg_unit #(
  parameter int VLEN = 64,
  parameter int ELEN = 32
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_avl,
  input  logic [31:0] req_vtype,
  input  logic        req_rs1_x0,
  input  logic        req_rd_x0,
  input  logic        req_imm,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] rd_data,
  output logic [31:0] vl,
  output logic [31:0] vtype,
  output logic [31:0] vlmax,
  output logic [31:0] vlenb
);

  // state | meaning
  // IDLE  | ready for a request
  // DECODE| decode latched vtype into SEW/LMUL/VLMAX/illegal
  // COMMIT| compute new vl, pulse resp_valid, update architectural state
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [31:0] VLEN_W = 32'(VLEN);
  localparam logic [31:0] ELEN_W = 32'(ELEN);

  logic [1:0]  state_q, state_d;
  logic [31:0] avl_q, vtype_req_q;
  logic        rs1_x0_q, rd_x0_q, imm_q;
  logic        ill_q;
  logic [31:0] cand_vlmax_q;
  logic [31:0] vl_q, vtype_q, vlmax_q;

  logic [2:0]  vsew, vlmul;
  logic [31:0] sew_bits, base_vlmax, dec_vlmax;
  logic        dec_ill;
  logic [31:0] avl_sel, new_vl, new_vtype, new_vlmax;
  logic        req_fire, commit_fire;
`ifdef RV32V_FRAC_LMUL_EN
  logic [1:0]  frac_shift;
`endif

  assign req_ready   = (state_q == ST_IDLE);
  assign req_fire    = req_valid && req_ready;
  assign commit_fire = (state_q == ST_COMMIT) && !flush;
  assign resp_valid  = commit_fire && nRST;
  assign rd_data     = resp_valid ? new_vl : 32'd0;
  assign vl          = vl_q;
  assign vtype       = vtype_q;
  assign vlmax       = vlmax_q;
  assign vlenb       = VLEN_W >> 3;

  always_comb begin
    vsew       = vtype_req_q[5:3];
    vlmul      = vtype_req_q[2:0];
    sew_bits   = 32'd8 << vsew;
    base_vlmax = VLEN_W >> ({1'b0, vsew} + 4'd3);
    dec_ill    = (vtype_req_q[31:8] != 24'd0) || vsew[2] || (sew_bits > ELEN_W) ||
                 (vlmul == 3'b100);
    dec_vlmax  = base_vlmax << vlmul[1:0];
`ifdef RV32V_FRAC_LMUL_EN
    // 101/110/111 map to right shifts of 3/2/1
    frac_shift = 2'd0 - vlmul[1:0];
    if (vlmul[2]) begin
      dec_vlmax = base_vlmax >> frac_shift;
      if (sew_bits > (ELEN_W >> frac_shift)) dec_ill = 1'b1;
    end
`else
    if (vlmul[2]) begin
      dec_vlmax = 32'd0;
      dec_ill   = 1'b1;
    end
`endif
    if (dec_vlmax == 32'd0) dec_ill = 1'b1;
  end

  always_comb begin
    avl_sel = avl_q;
    // rs1=x0: rd=x0 keeps the current vl (clamped), otherwise request VLMAX
    if (!imm_q && rs1_x0_q) avl_sel = rd_x0_q ? vl_q : 32'hFFFF_FFFF;
    new_vl    = ill_q ? 32'd0 : ((avl_sel < cand_vlmax_q) ? avl_sel : cand_vlmax_q);
    new_vtype = ill_q ? 32'h8000_0000 : {24'd0, vtype_req_q[7:0]};
    new_vlmax = ill_q ? 32'd0 : cand_vlmax_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = flush ? ST_IDLE : ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      vl_q    <= 32'd0;
      vtype_q <= 32'h8000_0000;
      vlmax_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (commit_fire) begin
        vl_q    <= new_vl;
        vtype_q <= new_vtype;
        vlmax_q <= new_vlmax;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (req_fire) begin
      avl_q       <= req_avl;
      vtype_req_q <= req_vtype;
      rs1_x0_q    <= req_rs1_x0;
      rd_x0_q     <= req_rd_x0;
      imm_q       <= req_imm;
    end
    if (state_q == ST_DECODE) begin
      ill_q        <= dec_ill;
      cand_vlmax_q <= dec_ill ? 32'd0 : dec_vlmax;
    end
  end

endmodule

// File: tb/tb_rv32v_vcfg_unit.sv
// Bench for rv32v_vcfg_unit: rational-arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_rv32v_vcfg_unit;
  localparam int VLEN = 64;
  localparam int ELEN = 32;
`ifdef RV32V_FRAC_LMUL_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_avl = '0;
  logic [31:0] req_vtype = '0;
  logic        req_rs1_x0 = 1'b0;
  logic        req_rd_x0 = 1'b0;
  logic        req_imm = 1'b0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [31:0] rd_data, vl, vtype, vlmax, vlenb;

  rv32v_vcfg_unit #(.VLEN(VLEN), .ELEN(ELEN)) dut (
    .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready),
    .req_avl(req_avl), .req_vtype(req_vtype), .req_rs1_x0(req_rs1_x0),
    .req_rd_x0(req_rd_x0), .req_imm(req_imm), .flush(flush),
    .resp_valid(resp_valid), .rd_data(rd_data), .vl(vl), .vtype(vtype),
    .vlmax(vlmax), .vlenb(vlenb)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: pending request ages through 2 then 1 cycles; architectural state as plain values.
  int          m_cnt = 0;
  bit          m_known = 1'b0;
  logic [31:0] m_vl, m_vtype, m_vlmax, m_avl, m_vt;
  bit          m_r1, m_rd, m_im;
  int          resp_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] last_rd = '0;

  function automatic void model_cfg(input logic [31:0] vt, output bit ill, output logic [31:0] vmax);
    int vsew, vlmul, sew, num, den;
    vsew = int'(vt[5:3]);
    vlmul = int'(vt[2:0]);
    ill = (vt[31:8] != 0) || (vsew >= 4);
    sew = 8 << vsew;
    if (sew > ELEN) ill = 1'b1;
    num = 1; den = 1;
    if (vlmul < 4) num = 1 << vlmul;
    else if (vlmul == 4) ill = 1'b1;
    else if (FRAC) den = 1 << (8 - vlmul);
    else ill = 1'b1;
    if (sew * den > ELEN * num) ill = 1'b1;
    vmax = 32'((VLEN * num) / (sew * den));
    if (vmax == 0) ill = 1'b1;
    if (ill) vmax = 0;
  endfunction

  function automatic void model_result(input logic [31:0] avl, input logic [31:0] vt,
                                       input bit r1, input bit rd, input bit im,
                                       input logic [31:0] cur_vl, output logic [31:0] nvl,
                                       output logic [31:0] nvt, output logic [31:0] nvmax);
    bit ill;
    logic [31:0] vmax, a;
    model_cfg(vt, ill, vmax);
    if (im || !r1) a = avl;
    else if (!rd) a = 32'hFFFF_FFFF;
    else a = cur_vl;
    nvl = ill ? 32'd0 : ((a < vmax) ? a : vmax);
    nvt = ill ? 32'h8000_0000 : {24'd0, vt[7:0]};
    nvmax = vmax;
  endfunction

  always @(posedge CLK) begin
    logic [31:0] a, b, c;
    if (!nRST) begin
      m_cnt = 0; m_vl = 0; m_vtype = 32'h8000_0000; m_vlmax = 0; m_known = 1'b1;
    end else if (m_cnt == 0) begin
      if (req_valid) begin
        m_avl = req_avl; m_vt = req_vtype; m_r1 = req_rs1_x0; m_rd = req_rd_x0; m_im = req_imm;
        m_cnt = 2;
      end
    end else if (m_cnt == 2) begin
      m_cnt = flush ? 0 : 1;
    end else begin
      if (!flush) begin
        model_result(m_avl, m_vt, m_r1, m_rd, m_im, m_vl, a, b, c);
        m_vl = a; m_vtype = b; m_vlmax = c;
      end
      m_cnt = 0;
    end
  end

  always @(negedge CLK) begin
    logic [31:0] a, b, c;
    bit exp_resp;
    if (m_known) begin
      exp_resp = (m_cnt == 1) && !flush && nRST;
      a = 0;
      if (exp_resp) model_result(m_avl, m_vt, m_r1, m_rd, m_im, m_vl, a, b, c);
      chk("req_ready", {31'd0, req_ready}, {31'd0, m_cnt == 0});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_resp});
      chk("rd_data", rd_data, a);
      chk("vl", vl, m_vl);
      chk("vtype", vtype, m_vtype);
      chk("vlmax", vlmax, m_vlmax);
      chk("vlenb", vlenb, 32'(VLEN / 8));
      if (resp_valid === 1'b1) begin resp_cnt++; last_rd = rd_data; end
      if (req_valid && req_ready === 1'b1) hs_cnt++;
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic issue(input logic [31:0] avl, input logic [31:0] vt,
                       input bit r1, input bit rd, input bit im);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 10) begin tick(); guard++; end
    chk("issue_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_avl = avl; req_vtype = vt;
    req_rs1_x0 = r1; req_rd_x0 = rd; req_imm = im;
    tick();
    req_valid = 1'b0; req_avl = $urandom; req_vtype = $urandom;
    tick();
    tick();
  endtask

  initial begin
    int rc;
    nRST = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    chk("rst_vl", vl, 32'd0);
    chk("rst_vtype", vtype, 32'h8000_0000);
    chk("rst_vlmax", vlmax, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    issue(5, 32'h00, 0, 0, 0);
    chk("basic_rd", last_rd, 32'd5); chk("basic_vl", vl, 32'd5);
    chk("basic_vlmax", vlmax, 32'd8); chk("basic_vtype", vtype, 32'h00);
    chk("model_basic_vl", m_vl, 32'd5);

    issue(100, 32'h11, 0, 0, 0);
    chk("sat_vl", vl, 32'd4); chk("sat_vlmax", vlmax, 32'd4);
    chk("model_sat_vlmax", m_vlmax, 32'd4);
    issue(2, 32'h11, 0, 0, 0);
    chk("small_vl", vl, 32'd2);
    issue(0, 32'h11, 1, 0, 0);
    chk("rdonly_vl", vl, 32'd4);
    issue(0, 32'h00, 1, 1, 0);
    chk("keep_vl", vl, 32'd4); chk("keep_vlmax", vlmax, 32'd8);
    issue(31, 32'h10, 1, 1, 1);
    chk("imm_vl", vl, 32'd2);

    issue(7, 32'h18, 0, 0, 0);
    chk("sew64_vl", vl, 32'd0); chk("sew64_vtype", vtype, 32'h8000_0000);
    chk("sew64_rd", last_rd, 32'd0);
    chk("model_sew64_vtype", m_vtype, 32'h8000_0000);
    issue(3, 32'h100, 0, 0, 0);
    chk("resv_vtype", vtype, 32'h8000_0000);

    issue(9, 32'h07, 0, 0, 0);
    chk("frac_vl", vl, FRAC ? 32'd4 : 32'd0);
    chk("frac_vlmax", vlmax, FRAC ? 32'd4 : 32'd0);
    chk("frac_vtype", vtype, FRAC ? 32'h07 : 32'h8000_0000);
    issue(9, 32'h17, 0, 0, 0);
    chk("frac32_vtype", vtype, 32'h8000_0000);

    issue(3, 32'h00, 0, 0, 0);
    rc = resp_cnt;
    req_valid = 1'b1; req_avl = 6; req_vtype = 32'h00; req_rs1_x0 = 0; req_rd_x0 = 0; req_imm = 0;
    tick();
    req_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("flush_noresp", 32'(resp_cnt - rc), 32'd0);
    chk("flush_vl", vl, 32'd3);

    rc = resp_cnt;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    chk("rstc_noresp", 32'(resp_cnt - rc), 32'd0);
    chk("rstc_vl", vl, 32'd0); chk("rstc_vtype", vtype, 32'h8000_0000);

    rc = hs_cnt;
    req_valid = 1'b1; req_avl = 3; req_vtype = 32'h08;
    repeat (6) tick();
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(hs_cnt - rc), 32'd2);
    chk("b2b_vl", vl, 32'd3);
    chk("b2b_vlmax", vlmax, 32'd4);

    for (int i = 0; i < 600; i++) begin
      nRST = ($urandom_range(0, 99) != 0);
      req_valid = $urandom_range(0, 1);
      flush = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: req_vtype = {29'd0, 3'($urandom_range(0, 7))} | (32'($urandom_range(0, 3)) << 3);
        1: req_vtype = {24'd0, 8'($urandom)};
        2: req_vtype = $urandom;
        default: req_vtype = {26'd0, 6'($urandom)};
      endcase
      req_avl = $urandom_range(0, 1) ? 32'($urandom_range(0, 20)) : $urandom;
      req_rs1_x0 = $urandom_range(0, 1);
      req_rd_x0 = $urandom_range(0, 1);
      req_imm = ($urandom_range(0, 3) == 0);
      tick();
    end
    nRST = 1'b1; req_valid = 1'b0; flush = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
